hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_operand_match.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/bypass controller.
//   SEL_RF     - bypass select value meaning "use the register file"
//   SEL_MEM()  - bypass select value meaning "use memory read data at M"
//   slot_t     - one in-flight destination entry {valid, dest, is_load}
//   md_state_t - mult/div occupancy states
package hazard_pkg;

  // Wide enough for any practical register count; narrower register
  // indices are zero-extended before being stored or compared.
  localparam int unsigned DEST_W = 16;

  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              is_load;
  } slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  function automatic int unsigned SEL_MEM(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_match.sv
// operand_match: resolves one source operand against the in-flight slots.
//   reg_i      - operand register index
//   use_i      - operand is actually read
//   slots_i    - scoreboard slots, index 0 = X (youngest)
//   sel_o      - bypass select (0 = regfile, k = ALU of slot k-1, DEPTH+1 = mem)
//   load_use_o - operand depends on a load still in X: decode must stall
import hazard_pkg::*;

module operand_match #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RW    = 5,
  parameter int unsigned SW    = 3
) (
  input  logic [RW-1:0]          reg_i,
  input  logic                   use_i,
  input  slot_t [DEPTH-1:0]      slots_i,
  output logic [SW-1:0]          sel_o,
  output logic                   load_use_o
);

  logic [DEST_W-1:0] regExt;
  assign regExt = DEST_W'(reg_i);

  // Walk from oldest to youngest so the youngest match is the last one
  // assigned and therefore wins.
  always_comb begin
    sel_o      = SW'(SEL_RF);
    load_use_o = 1'b0;
    if (use_i && (reg_i != '0)) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (slots_i[k].valid && (slots_i[k].dest == regExt)) begin
          if (slots_i[k].is_load && (k == 0)) begin
            sel_o      = SW'(SEL_RF);
            load_use_o = 1'b1;
          end else if (slots_i[k].is_load && (k == 1)) begin
            sel_o      = SW'(SEL_MEM(DEPTH));
            load_use_o = 1'b0;
          end else begin
            sel_o      = SW'(k + 1);
            load_use_o = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and bypass controller beside the decode stage.
//   clock, reset_n            - rising-edge clock, async active-low reset
//   fd_*                      - decode-slot instruction fields and flags
//   flush                     - kills the decode instruction
//   md_ready                  - mult/div result valid pulse
//   sel_a, sel_b, sel_d       - operand bypass selects
//   stall                     - hold PC/FD, bubble into X
//   md_busy, md_wb, md_dest   - mult/div occupancy, writeback pulse, dest
//   md_err                    - sticky mult/div timeout flag
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned MD_TIMEOUT = 64,
  localparam int unsigned RW = $clog2(NUM_REGS),
  localparam int unsigned SW = $clog2(DEPTH + 2),
  localparam int unsigned CW = $clog2(MD_TIMEOUT + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          fd_valid,
  input  logic [RW-1:0] fd_rs,
  input  logic [RW-1:0] fd_rt,
  input  logic [RW-1:0] fd_rd,
  input  logic          fd_use_s,
  input  logic          fd_use_t,
  input  logic          fd_use_d,
  input  logic          fd_wr,
  input  logic          fd_is_load,
  input  logic          fd_is_md,
  input  logic          flush,
  input  logic          md_ready,
  output logic [SW-1:0] sel_a,
  output logic [SW-1:0] sel_b,
  output logic [SW-1:0] sel_d,
  output logic          stall,
  output logic          md_busy,
  output logic          md_wb,
  output logic [RW-1:0] md_dest,
  output logic          md_err
);

  slot_t [DEPTH-1:0] slots_q, slots_d;
  md_state_t         md_state_q, md_state_d;
  logic [RW-1:0]     md_dest_q, md_dest_d;
  logic [CW-1:0]     md_cnt_q, md_cnt_d;
  logic              md_err_q, md_err_d;

  logic luA, luB, luD;
  logic loadUse, mdStall, mdReadHit, mdWriteHit, mdIssue;

  operand_match #(.DEPTH(DEPTH), .RW(RW), .SW(SW)) u_match_a (
    .reg_i(fd_rs), .use_i(fd_use_s), .slots_i(slots_q), .sel_o(sel_a), .load_use_o(luA)
  );
  operand_match #(.DEPTH(DEPTH), .RW(RW), .SW(SW)) u_match_b (
    .reg_i(fd_rt), .use_i(fd_use_t), .slots_i(slots_q), .sel_o(sel_b), .load_use_o(luB)
  );
  operand_match #(.DEPTH(DEPTH), .RW(RW), .SW(SW)) u_match_d (
    .reg_i(fd_rd), .use_i(fd_use_d), .slots_i(slots_q), .sel_o(sel_d), .load_use_o(luD)
  );

  assign loadUse = luA | luB | luD;

  // While mult/div is outstanding the decode instruction must wait if it
  // touches md_dest in any way or needs the unit itself. md_ready in the
  // same cycle does not release it: the regfile is only written at the edge.
  assign mdReadHit  = (fd_use_s && (fd_rs != '0) && (fd_rs == md_dest_q)) ||
                      (fd_use_t && (fd_rt != '0) && (fd_rt == md_dest_q)) ||
                      (fd_use_d && (fd_rd != '0) && (fd_rd == md_dest_q));
  assign mdWriteHit = fd_wr && (fd_rd != '0) && (fd_rd == md_dest_q);
  assign mdStall    = (md_state_q == BUSY) && (mdReadHit || mdWriteHit || fd_is_md);

  assign stall   = fd_valid && !flush && (loadUse || mdStall);
  assign mdIssue = fd_valid && fd_is_md && !stall && !flush;

  // Mult/div results bypass the slot pipeline, so they never enter slot 0.
  always_comb begin
    slots_d = slots_q;
    slots_d[0].valid   = fd_valid && fd_wr && (fd_rd != '0) && !stall && !flush && !fd_is_md;
    slots_d[0].dest    = DEST_W'(fd_rd);
    slots_d[0].is_load = fd_is_load;
    for (int k = 1; k < int'(DEPTH); k++) begin
      slots_d[k] = slots_q[k-1];
    end
  end

  always_comb begin
    md_state_d = md_state_q;
    md_dest_d  = md_dest_q;
    md_cnt_d   = md_cnt_q;
    md_err_d   = md_err_q;
    md_wb      = 1'b0;
    case (md_state_q)
      IDLE: begin
        if (mdIssue) begin
          md_state_d = BUSY;
          md_dest_d  = fd_rd;
          md_cnt_d   = '0;
        end
      end
      BUSY: begin
        if (md_ready) begin
          md_state_d = IDLE;
          md_wb      = 1'b1;
        end else if (md_cnt_q != CW'(MD_TIMEOUT)) begin
          md_cnt_d = md_cnt_q + 1'b1;
          if (md_cnt_q == CW'(MD_TIMEOUT - 1)) begin
            md_err_d = 1'b1;
          end
        end
      end
      default: md_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slots_q    <= '0;
      md_state_q <= IDLE;
      md_dest_q  <= '0;
      md_cnt_q   <= '0;
      md_err_q   <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      md_state_q <= md_state_d;
      md_dest_q  <= md_dest_d;
      md_cnt_q   <= md_cnt_d;
      md_err_q   <= md_err_d;
    end
  end

  assign md_busy = (md_state_q == BUSY);
  assign md_dest = md_dest_q;
  assign md_err  = md_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard
// at NUM_REGS=32, DEPTH=3, MD_TIMEOUT=64. Slot 0 = X, 1 = M, 2 = W.
module tb_hazard_scoreboard;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DEPTH      = 3;
  localparam int unsigned MD_TIMEOUT = 64;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       fd_valid;
  logic [4:0] fd_rs, fd_rt, fd_rd;
  logic       fd_use_s, fd_use_t, fd_use_d;
  logic       fd_wr, fd_is_load, fd_is_md;
  logic       flush, md_ready;
  logic [2:0] sel_a, sel_b, sel_d;
  logic       stall, md_busy, md_wb, md_err;
  logic [4:0] md_dest;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
    logic       stall;
    logic       busy;
    logic       wb;
    logic [4:0] dest;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int compareCount  = 0;
  int mismatchCount = 0;

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_use_s(fd_use_s), .fd_use_t(fd_use_t), .fd_use_d(fd_use_d),
    .fd_wr(fd_wr), .fd_is_load(fd_is_load), .fd_is_md(fd_is_md),
    .flush(flush), .md_ready(md_ready),
    .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .stall(stall),
    .md_busy(md_busy), .md_wb(md_wb), .md_dest(md_dest), .md_err(md_err)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic us, input logic ut,
                               input logic ud, input logic wr, input logic ld,
                               input logic md, input logic fl, input logic rdy);
    fd_valid = v;  fd_rs = rs;  fd_rt = rt;  fd_rd = rd;
    fd_use_s = us; fd_use_t = ut; fd_use_d = ud;
    fd_wr = wr; fd_is_load = ld; fd_is_md = md;
    flush = fl; md_ready = rdy;
  endtask

  task automatic expectOut(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                           input logic st, input logic busy, input logic wb,
                           input logic [4:0] dest, input logic err);
    exp_t e;
    e.a = a; e.b = b; e.d = d; e.stall = st; e.busy = busy;
    e.wb = wb; e.dest = dest; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic compareField(input string tag, input string field,
                              input logic [31:0] obs, input logic [31:0] expv);
    compareCount++;
    assert (obs === expv) else begin
      mismatchCount++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clock);
    if (expQ.size() == 0) begin
      compareCount++;
      mismatchCount++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = expQ.pop_front();
      compareField(tag, "sel_a",   32'(sel_a),   32'(e.a));
      compareField(tag, "sel_b",   32'(sel_b),   32'(e.b));
      compareField(tag, "sel_d",   32'(sel_d),   32'(e.d));
      compareField(tag, "stall",   32'(stall),   32'(e.stall));
      compareField(tag, "md_busy", 32'(md_busy), 32'(e.busy));
      compareField(tag, "md_wb",   32'(md_wb),   32'(e.wb));
      compareField(tag, "md_dest", 32'(md_dest), 32'(e.dest));
      compareField(tag, "md_err",  32'(md_err),  32'(e.err));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    $display("[TB] start");
    reset_n = 1'b0;
    idle(0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset");
    tick();
    reset_n = 1'b1;

    // ALU forwarding by age: r3 in X, then M, then W
    applyStimulus(1, 1, 2, 3, 1, 1, 0, 1, 0, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("add_r3"); tick();
    applyStimulus(1, 3, 5, 4, 1, 1, 0, 1, 0, 0, 0, 0);
    expectOut(1, 0, 0, 0, 0, 0, 0, 0); checkOutput("fwd_x"); tick();
    applyStimulus(1, 3, 0, 10, 1, 1, 0, 1, 0, 0, 0, 0);
    expectOut(2, 0, 0, 0, 0, 0, 0, 0); checkOutput("fwd_m_r0"); tick();
    applyStimulus(1, 3, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    expectOut(3, 2, 0, 0, 0, 0, 0, 0); checkOutput("fwd_w"); tick();

    // Load-use: one stall then memory bypass, later ALU-slot select from W
    applyStimulus(1, 1, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("lw_r6"); tick();
    applyStimulus(1, 6, 6, 7, 1, 1, 0, 1, 0, 0, 0, 0);
    expectOut(0, 0, 0, 1, 0, 0, 0, 0); checkOutput("load_use"); tick();
    expectOut(4, 4, 0, 0, 0, 0, 0, 0); checkOutput("load_mem"); tick();
    applyStimulus(1, 6, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    expectOut(3, 1, 0, 0, 0, 0, 0, 0); checkOutput("load_w"); tick();

    // r2 in X and M: youngest wins for the rd operand; r0 operands stay 0
    applyStimulus(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("add_r2_a"); tick();
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("add_r2_b"); tick();
    applyStimulus(1, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    expectOut(0, 0, 1, 0, 0, 0, 0, 0); checkOutput("sw_youngest"); tick();

    // Flush overrides load-use and bubbles slot 0
    applyStimulus(1, 0, 0, 11, 0, 0, 0, 1, 1, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("lw_r11"); tick();
    applyStimulus(1, 11, 0, 12, 1, 0, 0, 1, 0, 0, 1, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("flush"); tick();
    applyStimulus(1, 12, 11, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    expectOut(0, 4, 0, 0, 0, 0, 0, 0); checkOutput("flush_bubble"); tick();

    // mul r8 then a dependent add waits until the cycle after md_ready
    applyStimulus(1, 1, 0, 8, 1, 0, 0, 1, 0, 1, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mul_r8"); tick();
    applyStimulus(1, 8, 1, 9, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expectOut(0, 0, 0, 1, 1, 0, 8, 0); checkOutput("md_raw_wait"); tick();
    end
    md_ready = 1'b1;
    expectOut(0, 0, 0, 1, 1, 1, 8, 0); checkOutput("md_ready"); tick();
    md_ready = 1'b0;
    expectOut(0, 0, 0, 0, 0, 0, 8, 0); checkOutput("md_release"); tick();

    // WAW and second mul/div stall; unrelated instruction proceeds
    applyStimulus(1, 0, 0, 13, 0, 0, 0, 1, 0, 1, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 8, 0); checkOutput("mul_r13"); tick();
    applyStimulus(1, 0, 0, 13, 0, 0, 0, 1, 0, 0, 0, 0);
    expectOut(0, 0, 0, 1, 1, 0, 13, 0); checkOutput("md_waw"); tick();
    applyStimulus(1, 0, 0, 14, 0, 0, 0, 1, 0, 1, 0, 0);
    expectOut(0, 0, 0, 1, 1, 0, 13, 0); checkOutput("md_md"); tick();
    applyStimulus(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expectOut(0, 0, 0, 0, 1, 0, 13, 0); checkOutput("md_indep"); tick();

    // Timeout: busy counter reaches 64 during the second loop at i == 6
    idle(0);
    for (int i = 0; i < 55; i++) begin
      expectOut(0, 0, 0, 0, 1, 0, 13, 0); checkOutput("md_wait"); tick();
    end
    for (int i = 0; i < 10; i++) begin
      expectOut(0, 0, 0, 0, 1, 0, 13, (i >= 6)); checkOutput("md_timeout"); tick();
    end
    idle(1);
    expectOut(0, 0, 0, 0, 1, 1, 13, 1); checkOutput("late_ready"); tick();
    idle(0);
    expectOut(0, 0, 0, 0, 0, 0, 13, 1); checkOutput("err_sticky"); tick();

    // Reset in the middle of a mult/div with a load in flight
    applyStimulus(1, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 13, 1); checkOutput("mul_r5"); tick();
    applyStimulus(1, 0, 0, 6, 0, 0, 0, 1, 1, 0, 0, 0);
    expectOut(0, 0, 0, 0, 1, 0, 5, 1); checkOutput("lw_busy"); tick();
    reset_n = 1'b0;
    applyStimulus(1, 6, 5, 7, 1, 1, 0, 1, 0, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mid_reset"); tick();
    reset_n = 1'b1;
    idle(1);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("stale_ready"); tick();
    applyStimulus(1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expectOut(0, 0, 0, 0, 0, 0, 0, 0); checkOutput("slots_cleared"); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
